// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with write-to-read bypass, aux write port
// and a per-register busy scoreboard that flags RAW hazards to the hazard unit.
module reg_file_sb #(
    parameter int DW      = 16,
    parameter int AW      = 4,
    parameter int AUX_REG = 15,
    parameter int ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          aux_wr_en,
    input  logic [DW-1:0] aux_data,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic [DW-1:0] rd_data1,
    output logic [DW-1:0] rd_data2,
    output logic [DW-1:0] aux_out,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_addr,
    output logic          hazard1,
    output logic          hazard2,
    output logic [AW:0]   busy_cnt
);
    localparam int N = 1 << AW;
    logic [DW-1:0] regs [N];
    logic [N-1:0]  busy, main_hit, aux_hit, set_hit;
    // One-hot write/issue targets; a hardwired R0 simply never gets hit.
    always_comb begin
        main_hit = '0;
        set_hit  = '0;
        aux_hit  = '0;
        for (int i = 0; i < N; i++) begin
            main_hit[i] = wr_en && wr_addr == AW'(i);
            set_hit[i]  = issue_en && issue_addr == AW'(i);
        end
        aux_hit[AUX_REG] = aux_wr_en;
        if (ZERO_R0 != 0) begin
            main_hit[0] = 1'b0;
            aux_hit[0]  = 1'b0;
            set_hit[0]  = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (aux_hit[i]) regs[i] <= aux_data;
                else if (main_hit[i]) regs[i] <= wr_data;
            busy <= set_hit | (busy & ~(main_hit | aux_hit));
        end
    end
    assign rd_data1 = (ZERO_R0 != 0 && rd_addr1 == '0) ? '0 :
                      aux_hit[rd_addr1] ? aux_data : main_hit[rd_addr1] ? wr_data : regs[rd_addr1];
    assign rd_data2 = (ZERO_R0 != 0 && rd_addr2 == '0) ? '0 :
                      aux_hit[rd_addr2] ? aux_data : main_hit[rd_addr2] ? wr_data : regs[rd_addr2];
    assign hazard1  = busy[rd_addr1] & ~(aux_hit[rd_addr1] | main_hit[rd_addr1]);
    assign hazard2  = busy[rd_addr2] & ~(aux_hit[rd_addr2] | main_hit[rd_addr2]);
    assign aux_out  = regs[AUX_REG];
    assign busy_cnt = (AW+1)'($countones(busy));
endmodule
